// File: rtl/core_pkg.sv
// Shared core definitions.
// Holds the stage encoding that appears on the sequencer's `state` bus.
// The fetch/decode/exec/mem/writeback blocks decode that bus by comparing
// it against these names.
package core_pkg;

  localparam int STATE_W = 3;

  // Codes 5 and 6 are unused and must never appear on the bus.
  typedef enum logic [STATE_W-1:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd7
  } stage_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the performance counters.
//   clk : clock
//   rst : asynchronous active-high reset, clears q
//   clr : synchronous clear; takes priority over inc
//   inc : count enable; q stops at all-ones and never wraps
//   q   : current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // NOTE: sequential state is written only with non-blocking assignments, so
  // every register samples values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Central multi-cycle stage controller.
// It drives the IF/ID/EX/MEM/WB/HALT stage bus. EX is held while a
// multi-cycle unit is busy. MEM dwells MEM_LAT cycles for loads. The block
// also handles start and halt, and it keeps saturating cycle and
// retired-instruction counters.
//   clk         : core clock
//   rst         : asynchronous active-high reset
//   start       : pulse; leaves HALT and clears the counters
//   halt_req    : halt instruction decoded (looked at only in ID)
//   exec_busy   : multi-cycle exec unit busy (looked at only in EX)
//   mem_read    : load in MEM (looked at only in MEM)
//   mem_write   : store in MEM (timing identical to a non-memory MEM cycle)
//   state       : registered stage code
//   running     : state != HALT
//   cycle_count : cycles spent outside HALT since the last start
//   instr_count : instructions retired since the last start
module stage_sequencer
  import core_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt_req,
  input  logic               exec_busy,
  input  logic               mem_read,
  input  logic               mem_write,
  output logic [STATE_W-1:0] state,
  output logic               running,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   instr_count
);

  // The wait counter value that ends a load's MEM dwell. MEM_LAT is at most
  // 8, so 3 bits are enough.
  localparam logic [2:0] MEM_LAST = 3'(MEM_LAT - 1);

  stage_e     stage_q;
  logic [2:0] mem_wait;

  // A store has the same one-cycle MEM as a non-memory instruction. The
  // write-enable comes from the mem block, so this input has no effect here.
  logic unused_mem_write;
  assign unused_mem_write = mem_write;

  // NOTE: asynchronous reset puts the stage bus into HALT at once, without
  // waiting for a clock edge. Only a start pulse leaves HALT afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q  <= ST_HALT;
      mem_wait <= '0;
    end else begin
      case (stage_q)
        ST_HALT: if (start) stage_q <= ST_IF;
        ST_IF:   stage_q <= ST_ID;
        ST_ID:   stage_q <= halt_req ? ST_HALT : ST_EX;
        ST_EX: begin
          if (!exec_busy) begin
            stage_q  <= ST_MEM;
            mem_wait <= '0;
          end
        end
        ST_MEM: begin
          // A load waits until the counter reaches MEM_LAT-1. Any other
          // instruction, including a store, leaves MEM after one cycle.
          if (mem_read && (mem_wait != MEM_LAST)) begin
            mem_wait <= mem_wait + 3'd1;
          end else begin
            stage_q <= ST_WB;
          end
        end
        ST_WB:   stage_q <= ST_IF;
        default: stage_q <= ST_HALT;
      endcase
    end
  end

  assign state   = stage_q;
  assign running = (stage_q != ST_HALT);

  // A halt instruction retires in ID. Every other instruction retires on
  // its WB edge.
  logic cnt_clr;
  logic instr_inc;
  assign cnt_clr   = (stage_q == ST_HALT) && start;
  assign instr_inc = (stage_q == ST_WB) || ((stage_q == ST_ID) && halt_req);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (running),
    .q   (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (instr_inc),
    .q   (instr_count)
  );

endmodule

// File: tb/tb_stage_sequencer.sv
// Testbench for stage_sequencer.
// The main instance uses MEM_LAT=3 and 32-bit counters. It is driven one
// instruction at a time, and the expected stage sequence for each
// instruction comes from its parameters (busy cycles, load/store, halt).
// Inputs that a stage does not look at are driven with random values.
// A second instance uses 4-bit counters to exercise saturation.
module tb_stage_sequencer;
  import core_pkg::*;

  localparam int MEM_LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, halt_req, exec_busy, mem_read, mem_write;
  logic [2:0]  state;
  logic        running;
  logic [31:0] cycle_count, instr_count;

  logic        s_start, s_zero;
  logic [2:0]  s_state;
  logic        s_running;
  logic [3:0]  s_cyc, s_instr;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_cyc, exp_instr;

  stage_sequencer #(.MEM_LAT(MEM_LAT), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt_req    (halt_req),
    .exec_busy   (exec_busy),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .state       (state),
    .running     (running),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  stage_sequencer #(.MEM_LAT(1), .CNT_W(4)) dut_small (
    .clk         (clk),
    .rst         (rst),
    .start       (s_start),
    .halt_req    (s_zero),
    .exec_busy   (s_zero),
    .mem_read    (s_zero),
    .mem_write   (s_zero),
    .state       (s_state),
    .running     (s_running),
    .cycle_count (s_cyc),
    .instr_count (s_instr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Random stray start pulse while running; it must be ignored.
  function automatic logic junk_start();
    return ($urandom_range(0, 3) == 0);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One clock cycle. The bench expects stage st during this cycle. Outputs
  // are checked on the falling edge, then inputs are driven. After the
  // rising edge, the expected counters advance by the counting rules.
  task automatic step(input stage_e st, input logic eb, input logic hr,
                      input logic mr, input logic mw, input logic go);
    @(negedge clk);
    check("state", 32'(state), 32'(st));
    check("running", 32'(running), 32'(st != ST_HALT));
    check("cycle_count", cycle_count, exp_cyc);
    check("instr_count", instr_count, exp_instr);
    exec_busy = eb;
    halt_req  = hr;
    mem_read  = mr;
    mem_write = mw;
    start     = go;
    @(posedge clk);
    if (st == ST_HALT) begin
      if (go) begin
        exp_cyc   = 0;
        exp_instr = 0;
      end
    end else begin
      if (exp_cyc != '1) exp_cyc++;
      if ((st == ST_WB || (st == ST_ID && hr)) && exp_instr != '1) exp_instr++;
    end
  endtask

  // One instruction. busy = number of exec_busy cycles in EX, rd/wr =
  // load/store flags, hlt = halt instruction (retires in ID, then HALT).
  task automatic run_instr(input int busy, input logic rd, input logic wr, input logic hlt);
    step(ST_IF, rb(), rb(), rb(), rb(), junk_start());
    step(ST_ID, rb(), hlt, rb(), rb(), junk_start());
    if (hlt) return;
    for (int i = 0; i <= busy; i++) step(ST_EX, (i < busy), rb(), rb(), rb(), junk_start());
    for (int i = 0; i < (rd ? MEM_LAT : 1); i++) step(ST_MEM, rb(), rb(), rd, wr, junk_start());
    step(ST_WB, rb(), rb(), rb(), rb(), junk_start());
  endtask

  initial begin
    logic [31:0] c0;
    logic        hlt;
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; exec_busy = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; s_start = 1'b0; s_zero = 1'b0;
    exp_cyc = 0; exp_instr = 0;

    #1;
    check("reset_state", 32'(state), 32'(ST_HALT));
    check("reset_running", 32'(running), 32'd0);
    check("reset_cycle", cycle_count, 32'd0);
    check("reset_instr", instr_count, 32'd0);
    check("reset_small_state", 32'(s_state), 32'(ST_HALT));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle without start: stays in HALT, and the counters stay at 0.
    repeat (10) step(ST_HALT, rb(), rb(), rb(), rb(), 1'b0);

    // Three plain instructions.
    step(ST_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) run_instr(0, 1'b0, 1'b0, 1'b0);
    #1;
    check("three_instr_cycle", cycle_count, 32'd15);
    check("three_instr_retired", instr_count, 32'd3);

    // Busy EX for 4 cycles: the instruction takes 9 cycles.
    c0 = cycle_count;
    run_instr(4, 1'b0, 1'b0, 1'b0);
    #1;
    check("busy_instr_len", cycle_count - c0, 32'd9);

    // Load: 3 MEM cycles. Store: 1 MEM cycle. Both: 3 MEM cycles.
    c0 = cycle_count;
    run_instr(0, 1'b1, 1'b0, 1'b0);
    #1;
    check("load_instr_len", cycle_count - c0, 32'(4 + MEM_LAT));
    run_instr(0, 1'b0, 1'b1, 1'b0);
    run_instr(0, 1'b1, 1'b1, 1'b0);

    // Halt in ID of the second instruction after a fresh start.
    run_instr(0, 1'b0, 1'b0, 1'b1);
    step(ST_HALT, rb(), rb(), rb(), rb(), 1'b1);
    run_instr(0, 1'b0, 1'b0, 1'b0);
    run_instr(0, 1'b0, 1'b0, 1'b1);
    #1;
    check("halt_state", 32'(state), 32'(ST_HALT));
    check("halt_retired", instr_count, 32'd2);
    check("halt_cycle", cycle_count, 32'd7);
    repeat (4) step(ST_HALT, rb(), rb(), rb(), rb(), 1'b0);
    step(ST_HALT, rb(), rb(), rb(), rb(), 1'b1);

    // Random instruction mix.
    repeat (40) begin
      hlt = ($urandom_range(0, 5) == 0);
      run_instr($urandom_range(0, 5), rb(), rb(), hlt);
      if (hlt) step(ST_HALT, rb(), rb(), rb(), rb(), 1'b1);
    end

    // Asynchronous reset in the middle of a busy EX.
    step(ST_IF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(ST_ID, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(ST_EX, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    start = 1'b0; exec_busy = 1'b0; rst = 1'b1;
    #1;
    check("async_rst_state", 32'(state), 32'(ST_HALT));
    check("async_rst_running", 32'(running), 32'd0);
    check("async_rst_cycle", cycle_count, 32'd0);
    check("async_rst_instr", instr_count, 32'd0);
    #1;
    rst = 1'b0;
    exp_cyc = 0;
    exp_instr = 0;
    repeat (3) step(ST_HALT, rb(), rb(), rb(), rb(), 1'b0);

    // Saturation: the 4-bit counters stop at 15 and do not wrap.
    @(negedge clk);
    s_start = 1'b1;
    for (int n = 0; n < 90; n++) begin
      @(negedge clk);
      s_start = 1'b0;
      check("sat_running", 32'(s_running), 32'd1);
      check("sat_cycle", 32'(s_cyc), 32'(imin(n, 15)));
      check("sat_instr", 32'(s_instr), 32'(imin(n / 5, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
